// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache:
// geometry constants, controller states and address-field helpers.
package cache_pkg;
  localparam int ADDR_W              = 16;
  localparam int WORD_SIZE           = 16;
  localparam int LINE_WORDS          = 4;
  localparam int LINE_BITS           = WORD_SIZE * LINE_WORDS;
  localparam int OFF_W               = $clog2(LINE_WORDS);
  localparam int DEFAULT_MEM_LATENCY = 8;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESPOND} state_e;

  function automatic logic [OFF_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W-1:0];
  endfunction

  // Index and tag come back right-aligned in a full address-width word;
  // callers size-cast them to the field width they need.
  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                   input int idx_bits);
    logic [ADDR_W-1:0] mask;
    mask = (ADDR_W'(1) << idx_bits) - ADDR_W'(1);
    return (addr >> OFF_W) & mask;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                 input int idx_bits);
    return addr >> (idx_bits + OFF_W);
  endfunction
endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays of the direct-mapped cache: combinational lookup,
// synchronous whole-line fill and single-word update, valid bits cleared on reset.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int IDX_BITS = 2,
  parameter int TAG_W    = ADDR_W - IDX_BITS - OFF_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_BITS-1:0]  i_lk_idx,
  input  logic [TAG_W-1:0]     i_lk_tag,
  input  logic [OFF_W-1:0]     i_lk_off,
  output logic                 o_hit,
  output logic [WORD_SIZE-1:0] o_word,
  input  logic                 i_fill_en,
  input  logic [IDX_BITS-1:0]  i_fill_idx,
  input  logic [TAG_W-1:0]     i_fill_tag,
  input  logic [LINE_BITS-1:0] i_fill_data,
  input  logic                 i_upd_en,
  input  logic [IDX_BITS-1:0]  i_upd_idx,
  input  logic [OFF_W-1:0]     i_upd_off,
  input  logic [WORD_SIZE-1:0] i_upd_data
);
  localparam int LINES = 2 ** IDX_BITS;

  logic [LINES-1:0]     r_valid;
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [LINE_BITS-1:0] r_data [LINES];

  always_comb begin
    o_hit  = r_valid[i_lk_idx] && (r_tag[i_lk_idx] == i_lk_tag);
    o_word = r_data[i_lk_idx][i_lk_off*WORD_SIZE +: WORD_SIZE];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_fill_en) begin
      r_valid[i_fill_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_fill_idx]  <= i_fill_tag;
      r_data[i_fill_idx] <= i_fill_data;
    end else if (i_upd_en) begin
      r_data[i_upd_idx][i_upd_off*WORD_SIZE +: WORD_SIZE] <= i_upd_data;
    end
  end
endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller that
// initiates fixed-latency memory reads (line fills) and single-word writes.
module data_cache_ctrl
  import cache_pkg::*;
#(
  parameter int IDX_BITS    = 2,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_write,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);
  localparam int               TAG_W    = ADDR_W - IDX_BITS - OFF_W;
  localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY);

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  state_e                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
  logic                  r_cpu_ready, w_cpu_ready_nxt;
  logic [WORD_SIZE-1:0]  r_cpu_rdata, w_cpu_rdata_nxt;
  logic                  r_mem_read, w_mem_read_nxt;
  logic                  r_mem_write, w_mem_write_nxt;
  logic [ADDR_W-1:0]     r_mem_addr, w_mem_addr_nxt;
  logic [LINE_BITS-1:0]  r_mem_wdata, w_mem_wdata_nxt;
  logic [15:0]           r_hit_count, r_miss_count;

  logic                  w_hit;
  logic [WORD_SIZE-1:0]  w_word;
  logic [WORD_SIZE-1:0]  w_fill_word;
  logic                  w_fill_en, w_upd_en, w_hit_inc, w_miss_inc;
  logic [IDX_BITS-1:0]   w_lk_idx, w_fill_idx;
  logic [TAG_W-1:0]      w_lk_tag, w_fill_tag;
  logic [OFF_W-1:0]      w_lk_off, w_fill_off;

  // Lookup decodes the live CPU address (used only at acceptance); the fill
  // side works from the address latched at acceptance.
  assign w_lk_idx    = IDX_BITS'(addr_index(cpu_addr, IDX_BITS));
  assign w_lk_tag    = TAG_W'(addr_tag(cpu_addr, IDX_BITS));
  assign w_lk_off    = addr_offset(cpu_addr);
  assign w_fill_idx  = IDX_BITS'(addr_index(r_addr, IDX_BITS));
  assign w_fill_tag  = TAG_W'(addr_tag(r_addr, IDX_BITS));
  assign w_fill_off  = addr_offset(r_addr);
  assign w_fill_word = mem_rdata[w_fill_off*WORD_SIZE +: WORD_SIZE];

  cache_line_store #(
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W)
  ) u_store (
    .clk         (clk),
    .reset       (reset),
    .i_lk_idx    (w_lk_idx),
    .i_lk_tag    (w_lk_tag),
    .i_lk_off    (w_lk_off),
    .o_hit       (w_hit),
    .o_word      (w_word),
    .i_fill_en   (w_fill_en),
    .i_fill_idx  (w_fill_idx),
    .i_fill_tag  (w_fill_tag),
    .i_fill_data (mem_rdata),
    .i_upd_en    (w_upd_en),
    .i_upd_idx   (w_lk_idx),
    .i_upd_off   (w_lk_off),
    .i_upd_data  (cpu_wdata)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_cpu_ready_nxt = 1'b0;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_fill_en       = 1'b0;
    w_upd_en        = 1'b0;
    w_hit_inc       = 1'b0;
    w_miss_inc      = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_req) begin
          w_addr_nxt = cpu_addr;
          w_cnt_nxt  = CNT_W'(1);
          if (cpu_write) begin
            w_state_nxt     = WRITE;
            w_mem_write_nxt = 1'b1;
            w_mem_addr_nxt  = cpu_addr;
            w_mem_wdata_nxt = {{(LINE_BITS-WORD_SIZE){1'b0}}, cpu_wdata};
            w_upd_en        = w_hit;
            w_hit_inc       = w_hit;
          end else if (w_hit) begin
            w_state_nxt     = RESPOND;
            w_cpu_ready_nxt = 1'b1;
            w_cpu_rdata_nxt = w_word;
            w_hit_inc       = 1'b1;
          end else begin
            w_state_nxt    = FILL;
            w_mem_read_nxt = 1'b1;
            w_mem_addr_nxt = {cpu_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            w_miss_inc     = 1'b1;
          end
        end
      end
      FILL: begin
        if (r_cnt == CNT_LAST) begin
          w_fill_en       = 1'b1;
          w_mem_read_nxt  = 1'b0;
          w_cpu_ready_nxt = 1'b1;
          w_cpu_rdata_nxt = w_fill_word;
          w_state_nxt     = RESPOND;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      WRITE: begin
        if (r_cnt == CNT_LAST) begin
          w_mem_write_nxt = 1'b0;
          w_cpu_ready_nxt = 1'b1;
          w_cpu_rdata_nxt = '0;
          w_state_nxt     = RESPOND;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RESPOND: begin
        // The strobes are already low here, giving memory its re-arm gap.
        w_cpu_rdata_nxt = '0;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_cpu_ready  <= 1'b0;
      r_cpu_rdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cpu_ready  <= w_cpu_ready_nxt;
      r_cpu_rdata  <= w_cpu_rdata_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_hit_count  <= sat_inc(r_hit_count, w_hit_inc);
      r_miss_count <= sat_inc(r_miss_count, w_miss_inc);
    end
  end

  always_ff @(posedge clk) begin
    r_addr <= w_addr_nxt;
  end

  assign cpu_ready  = r_cpu_ready;
  assign cpu_rdata  = r_cpu_rdata;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: behavioural cache/memory model feeds a scoreboard;
// a CPU-side monitor and a fixed-latency memory device check the DUT.
`timescale 1ns/1ps
module tb_data_cache_ctrl;
  localparam int IDX_BITS = 2;
  localparam int LAT      = 8;
  localparam int NLINES   = 1 << IDX_BITS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_write = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  data_cache_ctrl #(.IDX_BITS(IDX_BITS), .MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Backing memory: the model's view and the device's view are kept apart so
  // that a wrong write from the DUT shows up on a later refill.
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] dev_mem [logic [15:0]];

  function automatic logic [15:0] mem_init(input logic [15:0] a);
    return (a == 16'h0023) ? 16'h6000 : (a ^ 16'hA5A5);
  endfunction
  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction
  function automatic logic [15:0] dev_rd(input logic [15:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : mem_init(a);
  endfunction

  typedef struct { logic [15:0] rdata; int lat; int hits; int misses; } exp_t;
  typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; } mexp_t;
  exp_t  expq[$];
  mexp_t memq[$];

  bit          m_valid [NLINES];
  int          m_tag   [NLINES];
  logic [15:0] m_line  [NLINES][4];
  int          m_hits;
  int          m_misses;

  task automatic model_reset();
    for (int i = 0; i < NLINES; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Cache semantics: direct-mapped lookup, refill whole line on load miss,
  // write-through always, update cached copy only on store hit.
  task automatic model_req(input bit wr, input logic [15:0] a, input logic [15:0] d);
    int    ia, idx, tag, off, base;
    bit    hit;
    exp_t  e;
    mexp_t m;
    ia   = int'(a);
    idx  = (ia >> 2) % NLINES;
    tag  = ia >> (IDX_BITS + 2);
    off  = ia % 4;
    base = ia - off;
    hit  = m_valid[idx] && (m_tag[idx] == tag);
    if (wr) begin
      if (hit) begin
        m_line[idx][off] = d;
        if (m_hits < 65535) m_hits++;
      end
      ref_mem[a] = d;
      m = '{wr: 1'b1, addr: a, data: d};
      memq.push_back(m);
      e = '{rdata: 16'h0, lat: LAT + 1, hits: m_hits, misses: m_misses};
    end else if (hit) begin
      if (m_hits < 65535) m_hits++;
      e = '{rdata: m_line[idx][off], lat: 1, hits: m_hits, misses: m_misses};
    end else begin
      if (m_misses < 65535) m_misses++;
      for (int k = 0; k < 4; k++) m_line[idx][k] = ref_rd(16'(base + k));
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m = '{wr: 1'b0, addr: 16'(base), data: 16'h0};
      memq.push_back(m);
      e = '{rdata: ref_rd(a), lat: LAT + 1, hits: m_hits, misses: m_misses};
    end
    expq.push_back(e);
  endtask

  // CPU-side monitor: pops one expectation per cpu_ready pulse.
  int   wcnt = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      wcnt = 0;
    end else if (cpu_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 required=0 rdata=%h", cpu_rdata);
      end else begin
        mon_e = expq.pop_front();
        chk("cpu_rdata", cpu_rdata, mon_e.rdata);
        chk("latency", wcnt, mon_e.lat);
        chk("hit_count", hit_count, mon_e.hits);
        chk("miss_count", miss_count, mon_e.misses);
      end
      wcnt = 0;
    end else if (cpu_req) begin
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // Memory device: data is valid only in the cycle before the capture edge,
  // and a write lands after the strobe has been high for the full latency.
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  mexp_t       mm;
  logic [15:0] mbase;
  always @(negedge clk) begin
    if (reset) begin
      rd_cyc    = 0;
      wr_cyc    = 0;
      mem_rdata = {$urandom, $urandom};
    end else begin
      if (mem_read && mem_write) begin
        checks++;
        failures++;
        $display("FAIL both_strobes actual=11 required=not_both");
      end
      if (mem_read) begin
        if (rd_cyc == 0) begin
          if (memq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_read actual=%h required=none", mem_addr);
          end else begin
            mm = memq.pop_front();
            chk("mem_op_is_read", mm.wr, 1'b0);
            chk("rd_addr", mem_addr, mm.addr);
          end
        end
        rd_cyc++;
        if (rd_cyc == LAT) begin
          mbase     = mem_addr & 16'hFFFC;
          mem_rdata = {dev_rd(mbase + 16'd3), dev_rd(mbase + 16'd2),
                       dev_rd(mbase + 16'd1), dev_rd(mbase)};
        end else begin
          mem_rdata = {$urandom, $urandom};
        end
      end else begin
        if (rd_cyc != 0) chk("rd_strobe_len", rd_cyc, LAT);
        rd_cyc    = 0;
        mem_rdata = {$urandom, $urandom};
      end
      if (mem_write) begin
        if (wr_cyc == 0) begin
          if (memq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%h required=none", mem_addr);
          end else begin
            mm = memq.pop_front();
            chk("mem_op_is_write", mm.wr, 1'b1);
            chk("wr_addr", mem_addr, mm.addr);
            chk("wr_data", mem_wdata, {48'h0, mm.data});
          end
        end
        wr_cyc++;
        if (wr_cyc == LAT) dev_mem[mem_addr] = mem_wdata[15:0];
      end else begin
        if (wr_cyc != 0) chk("wr_strobe_len", wr_cyc, LAT);
        wr_cyc = 0;
      end
    end
  end

  task automatic do_req(input bit wr, input logic [15:0] a, input logic [15:0] d);
    int n;
    n = 0;
    model_req(wr, a, d);
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_req   = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ready && n < 40);
    checks++;
    if (!cpu_ready) begin
      failures++;
      $display("FAIL ready_timeout actual=%0d_cycles required=ready addr=%h", n, a);
    end
    @(posedge clk);
    #1;
    cpu_req   = 1'b0;
    cpu_write = 1'($urandom);
    cpu_addr  = 16'($urandom);
    cpu_wdata = 16'($urandom);
  endtask

  task automatic reset_mid_fill(input logic [15:0] a);
    mexp_t m;
    m = '{wr: 1'b0, addr: a & 16'hFFFC, data: 16'h0};
    memq.push_back(m);
    cpu_write = 1'b0;
    cpu_addr  = a;
    cpu_req   = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("fill_active_before_reset", mem_read, 1'b1);
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("abort_mem_read", mem_read, 1'b0);
    chk("abort_mem_write", mem_write, 1'b0);
    chk("abort_cpu_ready", cpu_ready, 1'b0);
    chk("abort_hit_count", hit_count, 16'h0);
    chk("abort_miss_count", miss_count, 16'h0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  bit          r_wr;
  logic [15:0] r_a;
  initial begin
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 16'h0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_hit_count", hit_count, 16'h0);
    chk("rst_miss_count", miss_count, 16'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_req(1'b0, 16'h0023, 16'h0);
    do_req(1'b0, 16'h0021, 16'h0);
    do_req(1'b1, 16'h0022, 16'h1234);
    do_req(1'b0, 16'h0022, 16'h0);
    do_req(1'b1, 16'h0080, 16'hBEEF);
    do_req(1'b0, 16'h0080, 16'h0);
    do_req(1'b0, 16'h0020, 16'h0);
    do_req(1'b0, 16'h0030, 16'h0);
    do_req(1'b0, 16'h0020, 16'h0);

    reset_mid_fill(16'h0047);
    do_req(1'b0, 16'h0047, 16'h0);
    do_req(1'b0, 16'h0045, 16'h0);

    for (int i = 0; i < 200; i++) begin
      r_wr = ($urandom_range(0, 9) < 4);
      r_a  = 16'($urandom_range(0, 2) * 1024 + $urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) r_a = 16'($urandom);
      do_req(r_wr, r_a, 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (4) @(negedge clk);
    chk("expq_drained", expq.size(), 0);
    chk("memq_drained", memq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/data_cache_ctrl.md
Name: data_cache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache. It sits between the CPU data port and memory port 2, and acts as the initiator for that port. It issues held readM/writeM requests, counts the fixed memory latency, fills 4-word (64-bit) lines, and forwards single-word writes. It owns all timing on the memory side, because memory port 2 has no ready or ack signal.

Parameters:
IDX_BITS, 2, index width; number of lines is 2**IDX_BITS.
MEM_LATENCY, 8, rising edges between request assertion and the edge on which mem_rdata is valid and captured, or on which the write is complete.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
cpu_req  in  1  request valid; held by the CPU until cpu_ready.
cpu_write  in  1  1 = store, 0 = load.
cpu_addr  in  16  word address.
cpu_wdata  in  16  store data.
cpu_rdata  out  16  load data; valid only while cpu_ready=1.
cpu_ready  out  1  one-cycle completion pulse.
mem_read  out  1  readM2 to memory.
mem_write  out  1  writeM2 to memory.
mem_addr  out  16  address2 to memory.
mem_wdata  out  64  write data; the top level drives data2 from this when mem_write=1.
mem_rdata  in  64  data2 sampled from memory.
hit_count  out  16  saturating count of load and store hits.
miss_count  out  16  saturating count of load misses.

Behaviour:
- Address split: word offset is addr[1:0]. Index is addr[IDX_BITS+1:2]. Tag is addr[15:IDX_BITS+2].
- Line word k occupies bits [16k+15:16k].
- Reset values: all valid bits cleared; state IDLE; cpu_ready=0; cpu_rdata=0; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0; both counters 0.
- Reset mid-transaction: abort immediately. Memory strobes are low from the next cycle. No cpu_ready is issued. Any partially captured line is discarded.
- Edge 0 is the edge that accepts a request in IDLE.
- IDLE:
  - Accept when cpu_req=1.
  - Load hit (valid and tag match) -> RESPOND. cpu_ready=1 and cpu_rdata=word in the cycle after edge 0. hit_count++.
  - Load miss -> FILL. miss_count++.
  - Store (hit or miss) -> WRITE. On a hit, the cached word is updated at edge 0 and hit_count++. On a miss the line is not allocated.
- FILL:
  - mem_read=1 and mem_addr={cpu_addr[15:2],2'b00} from edge 0 through edge MEM_LATENCY.
  - At edge MEM_LATENCY: capture mem_rdata into the line, set tag and valid, drop mem_read, go to RESPOND with the requested word.
  - Load miss latency is MEM_LATENCY+1 cycles from acceptance to cpu_ready.
- WRITE:
  - mem_write=1, mem_addr=cpu_addr, mem_wdata={48'h0,cpu_wdata} from edge 0 through edge MEM_LATENCY.
  - Then go to RESPOND; cpu_rdata=0 for stores.
- RESPOND:
  - Lasts exactly one cycle: cpu_ready=1, mem_read=0, mem_write=0.
  - Then go to IDLE.
  - This guarantees at least one low cycle on the memory strobes between transactions, which the memory needs to re-arm its latency counter on a rising strobe.
- Latency counter: width is ceil(log2(MEM_LATENCY+1)). It loads 1 at edge 0 and increments each edge. Its terminal condition is counter==MEM_LATENCY.
- The cache never asserts mem_read and mem_write together.
- CPU handshake:
  - The CPU must hold cpu_req, cpu_write, cpu_addr and cpu_wdata stable until cpu_ready. The controller latches the address and data at edge 0 and uses only the latched copy afterwards.
  - In the cycle after cpu_ready, cpu_req may be asserted with a new request, which is accepted on the next IDLE edge.
  - Maximum throughput: one hit every 2 cycles.
- Counters saturate at 16'hFFFF and do not wrap.
- Store hit on the line currently being referenced by the same request: the cache and memory stay coherent; the cached word always equals the written word.

Decomposition:
- Shared package (cache_pkg):
  - WORD_SIZE=16, LINE_WORDS=4, LINE_BITS=64.
  - State enum {IDLE, FILL, WRITE, RESPOND}.
  - Default MEM_LATENCY.
  - Address-field helper functions (tag, index, offset).
- One sub-module, cache_line_store:
  - Valid, tag and 64-bit data arrays.
  - Combinational lookup (hit, word out).
  - Synchronous line fill and word update.
  - Synchronous clear on reset.

Test Plan:
- Reset, then load 0x0023 (memory holds 0x6000) -> mem_read high for 8 cycles, mem_addr=0x0020; cpu_ready one cycle later with cpu_rdata=0x6000; miss_count=1.
- Then load 0x0021 (same line) -> no mem_read; cpu_ready in the next cycle with the line word 1 value; hit_count=1.
- Store 0x1234 to 0x0022 (hit) -> cache word updated; mem_write high for 8 cycles, mem_addr=0x0022, mem_wdata[15:0]=0x1234; load 0x0022 then hits and returns 0x1234.
- Store to 0x0080 (miss) -> mem_write only; the following load of 0x0080 misses and fills from memory; miss_count increments.
- Conflict: load 0x0020, then 0x0030 (same index, IDX_BITS=2), then 0x0020 -> miss, miss, miss; each miss has exactly one low strobe cycle between transactions.
- Assert reset at cycle 4 of a FILL -> mem_read low next cycle, no cpu_ready; a reload of the same address misses; counters read 0.
